// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control FSM: opcodes, ALU ops, mux selects, states.
package mc_pkg;

    localparam int unsigned OP_W = 6;
    localparam int unsigned FN_W = 3;
    localparam int unsigned ST_W = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_LD    = 6'h23;
    localparam logic [OP_W-1:0] OP_SD    = 6'h2B;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [ST_W-1:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_ALU_WB   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    // State-only (Moore) datapath controls, registered inside the FSM
    typedef struct packed {
        logic       mem_rd;
        logic       mem_wr;
        logic       iord;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
    } ctrl_t;

    function automatic logic op_legal(logic [OP_W-1:0] op);
        return op inside {OP_RTYPE, OP_ADDI, OP_LD, OP_SD, OP_BEQ, OP_BNE, OP_J};
    endfunction

    function automatic ctrl_t moore_ctrl(state_e st, logic is_rtype);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH:    begin c.mem_rd = 1'b1; c.alu_src_b = SRCB_FOUR; end
            S_DECODE:   c.alu_src_b = SRCB_IMM_SH2;
            S_EXEC_R:   begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_REGB; end
            S_EXEC_I,
            S_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; end
            S_ALU_WB:   begin c.reg_we = 1'b1; c.reg_dst = is_rtype; end
            S_MEM_RD:   begin c.mem_rd = 1'b1; c.iord = 1'b1; end
            S_MEM_WB:   begin c.reg_we = 1'b1; c.mem_to_reg = 1'b1; end
            S_MEM_WR:   begin c.mem_wr = 1'b1; c.iord = 1'b1; end
            S_BRANCH:   begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REGB;
                c.pc_src    = PCSRC_ALUOUT;
            end
            S_JUMP:     c.pc_src = PCSRC_JUMP;
            default:    ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control <-> datapath/memory signal bundle; master = control FSM, slave = datapath.
interface multicycle_control_if;

    logic [mc_pkg::OP_W-1:0] opcode;
    logic [mc_pkg::FN_W-1:0] funct;
    logic                    zero;
    logic                    mem_ready;

    logic                    mem_rd;
    logic                    mem_wr;
    logic                    iord;
    logic                    ir_we;
    logic                    pc_we;
    logic [1:0]              pc_src;
    logic                    alu_src_a;
    logic [1:0]              alu_src_b;
    logic [2:0]              ALU_Op;
    logic                    reg_we;
    logic                    reg_dst;
    logic                    mem_to_reg;
    logic                    illegal;
    logic [mc_pkg::ST_W-1:0] state_dbg;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_rd, mem_wr, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
               ALU_Op, reg_we, reg_dst, mem_to_reg, illegal, state_dbg
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_rd, mem_wr, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
               ALU_Op, reg_we, reg_dst, mem_to_reg, illegal, state_dbg
    );

endinterface

// File: rtl/alu_op_decoder.sv
// Selects the ALU operation from the current control state and the R-type function field.
module alu_op_decoder
    import mc_pkg::*;
(
    input  state_e          state_i,
    input  logic [FN_W-1:0] funct_i,
    output alu_op_e         alu_op_o
);

    always_comb begin
        alu_op_o = ALU_ADD;
        case (state_i)
            S_EXEC_R: alu_op_o = alu_op_e'(funct_i);
            S_BRANCH: alu_op_o = ALU_SUB;
            default:  ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle processor: fetch/decode/execute/memory/writeback sequencing.
module multicycle_control
    import mc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master ctrl_io
);

    state_e  state_q, state_d;
    logic    is_bne_q, is_bne_d;
    ctrl_t   ctrl_q, ctrl_d;
    alu_op_e alu_op;

    // Next-state logic; Moore controls are precomputed for the state being entered
    always_comb begin
        state_d  = state_q;
        is_bne_d = is_bne_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (ctrl_io.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                is_bne_d = (ctrl_io.opcode == OP_BNE);
                case (ctrl_io.opcode)
                    OP_RTYPE:      state_d = S_EXEC_R;
                    OP_ADDI:       state_d = S_EXEC_I;
                    OP_LD, OP_SD:  state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    default:       state_d = S_FETCH;
                endcase
            end
            S_EXEC_R,
            S_EXEC_I:   state_d = S_ALU_WB;
            S_MEM_ADDR: state_d = (ctrl_io.opcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (ctrl_io.mem_ready) state_d = S_MEM_WB;
            S_MEM_WR:   if (ctrl_io.mem_ready) state_d = S_FETCH;
            S_ALU_WB,
            S_MEM_WB,
            S_BRANCH,
            S_JUMP:     state_d = S_FETCH;
            default:    state_d = S_IDLE;
        endcase
        ctrl_d = moore_ctrl(state_d, ctrl_io.opcode == OP_RTYPE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            is_bne_q <= 1'b0;
            ctrl_q   <= '0;
        end else begin
            state_q  <= state_d;
            is_bne_q <= is_bne_d;
            ctrl_q   <= ctrl_d;
        end
    end

    alu_op_decoder u_alu_op_decoder (
        .state_i  (state_q),
        .funct_i  (ctrl_io.funct),
        .alu_op_o (alu_op)
    );

    assign ctrl_io.mem_rd     = ctrl_q.mem_rd;
    assign ctrl_io.mem_wr     = ctrl_q.mem_wr;
    assign ctrl_io.iord       = ctrl_q.iord;
    assign ctrl_io.pc_src     = ctrl_q.pc_src;
    assign ctrl_io.alu_src_a  = ctrl_q.alu_src_a;
    assign ctrl_io.alu_src_b  = ctrl_q.alu_src_b;
    assign ctrl_io.reg_we     = ctrl_q.reg_we;
    assign ctrl_io.reg_dst    = ctrl_q.reg_dst;
    assign ctrl_io.mem_to_reg = ctrl_q.mem_to_reg;
    assign ctrl_io.ALU_Op     = alu_op;
    assign ctrl_io.state_dbg  = state_q;

    // Same-cycle responses to memory completion and the branch comparison
    assign ctrl_io.ir_we   = (state_q == S_FETCH) && ctrl_io.mem_ready;
    assign ctrl_io.pc_we   = ((state_q == S_FETCH) && ctrl_io.mem_ready)
                           || ((state_q == S_BRANCH) && (ctrl_io.zero ^ is_bne_q))
                           || (state_q == S_JUMP);
    assign ctrl_io.illegal = (state_q == S_DECODE) && !op_legal(ctrl_io.opcode);

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed instruction table, random program, reset corners.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctrl_io (bus)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       mem_rd, mem_wr, iord, ir_we, pc_we;
        logic [1:0] pc_src;
        logic       src_a;
        logic [1:0] src_b;
        logic [2:0] alu;
        logic       reg_we, reg_dst, mem_to_reg, illegal;
    } obs_t;

    typedef struct {
        logic [5:0] opcode;
        logic [2:0] funct;
        logic       zero;
        logic       ready;
        obs_t       exp;
    } vec_t;

    typedef struct {
        logic [5:0] op;
        logic [2:0] fn;
        logic       z;
        int         fwait;
        int         mwait;
        int         exp_lat;
    } dir_t;

    vec_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [5:0] legal_ops [7] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic bit is_legal(logic [5:0] op);
        for (int i = 0; i < 7; i++) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic obs_t base(int st);
        obs_t o;
        o = '0;
        o.st = 4'(st);
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st = bus.state_dbg;        o.mem_rd = bus.mem_rd;   o.mem_wr = bus.mem_wr;
        o.iord = bus.iord;           o.ir_we = bus.ir_we;     o.pc_we = bus.pc_we;
        o.pc_src = bus.pc_src;       o.src_a = bus.alu_src_a; o.src_b = bus.alu_src_b;
        o.alu = bus.ALU_Op;          o.reg_we = bus.reg_we;   o.reg_dst = bus.reg_dst;
        o.mem_to_reg = bus.mem_to_reg; o.illegal = bus.illegal;
        return o;
    endfunction

    function automatic void check(obs_t act, obs_t exp, string name);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (state got %0d want %0d)",
                     name, act, exp, act.st, exp.st);
        end
    endfunction

    function automatic void push(logic [5:0] op, logic [2:0] fn, logic z, logic rdy, obs_t e);
        vec_t v;
        v.opcode = op; v.funct = fn; v.zero = z; v.ready = rdy; v.exp = e;
        q.push_back(v);
    endfunction

    // Expected cycle-by-cycle trace of one instruction, from fetch to the cycle before the next fetch
    function automatic void build(logic [5:0] op, logic [2:0] fn, logic z, int fwait, int mwait);
        obs_t e;
        for (int i = 0; i <= fwait; i++) begin
            e = base(1); e.mem_rd = 1'b1; e.src_b = 2'b01;
            if (i == fwait) begin e.ir_we = 1'b1; e.pc_we = 1'b1; end
            push(6'($urandom), 3'($urandom), 1'($urandom), 1'(i == fwait), e);
        end
        e = base(2); e.src_b = 2'b11; e.illegal = !is_legal(op);
        push(op, fn, 1'($urandom), 1'($urandom), e);
        if (!is_legal(op)) return;
        case (op)
            6'h00, 6'h08: begin
                e = base(op == 6'h00 ? 3 : 4); e.src_a = 1'b1;
                e.src_b = (op == 6'h00) ? 2'b00 : 2'b10;
                e.alu   = (op == 6'h00) ? fn : 3'b000;
                push(op, fn, 1'($urandom), 1'($urandom), e);
                e = base(5); e.reg_we = 1'b1; e.reg_dst = (op == 6'h00);
                push(op, fn, 1'($urandom), 1'($urandom), e);
            end
            6'h23, 6'h2B: begin
                e = base(6); e.src_a = 1'b1; e.src_b = 2'b10;
                push(op, fn, 1'($urandom), 1'($urandom), e);
                for (int i = 0; i <= mwait; i++) begin
                    e = base(op == 6'h23 ? 7 : 9); e.iord = 1'b1;
                    if (op == 6'h23) e.mem_rd = 1'b1; else e.mem_wr = 1'b1;
                    push(op, fn, 1'($urandom), 1'(i == mwait), e);
                end
                if (op == 6'h23) begin
                    e = base(8); e.reg_we = 1'b1; e.mem_to_reg = 1'b1;
                    push(op, fn, 1'($urandom), 1'($urandom), e);
                end
            end
            6'h04, 6'h05: begin
                e = base(10); e.src_a = 1'b1; e.alu = 3'b001; e.pc_src = 2'b01;
                e.pc_we = z ^ (op == 6'h05);
                push(op, fn, z, 1'($urandom), e);
            end
            default: begin
                e = base(11); e.pc_src = 2'b10; e.pc_we = 1'b1;
                push(op, fn, 1'($urandom), 1'($urandom), e);
            end
        endcase
    endfunction

    // Entered and left just after a rising edge; lat counts DUT cycles seen outside IDLE
    task automatic run_queue(output int lat);
        vec_t v;
        obs_t a;
        lat = 0;
        while (q.size() > 0) begin
            v = q.pop_front();
            bus.opcode = v.opcode; bus.funct = v.funct;
            bus.zero = v.zero;     bus.mem_ready = v.ready;
            @(negedge clk);
            a = sample();
            if (a.st != 4'd0) lat++;
            check(a, v.exp, $sformatf("cyc%0d_st%0d", cyc, v.exp.st));
            @(posedge clk); #1;
        end
    endtask

    dir_t tbl [14];
    int   lat;
    obs_t e;
    logic [5:0] rop;

    initial begin
        tbl[0]  = '{6'h00, 3'd1, 1'b0, 0, 0, 4};   // R-type SUB
        tbl[1]  = '{6'h00, 3'd7, 1'b1, 1, 0, 5};   // R-type SLT, slow fetch
        tbl[2]  = '{6'h08, 3'd5, 1'b0, 0, 0, 4};   // ADDI
        tbl[3]  = '{6'h23, 3'd0, 1'b0, 0, 0, 5};   // LD fast
        tbl[4]  = '{6'h23, 3'd2, 1'b1, 0, 3, 8};   // LD slow memory
        tbl[5]  = '{6'h2B, 3'd0, 1'b0, 0, 0, 4};   // SD fast
        tbl[6]  = '{6'h2B, 3'd4, 1'b0, 2, 1, 7};   // SD slow fetch + memory
        tbl[7]  = '{6'h04, 3'd0, 1'b1, 0, 0, 3};   // BEQ taken
        tbl[8]  = '{6'h04, 3'd0, 1'b0, 0, 0, 3};   // BEQ not taken
        tbl[9]  = '{6'h05, 3'd0, 1'b0, 0, 0, 3};   // BNE taken
        tbl[10] = '{6'h05, 3'd0, 1'b1, 0, 0, 3};   // BNE not taken
        tbl[11] = '{6'h02, 3'd0, 1'b0, 0, 0, 3};   // J
        tbl[12] = '{6'h3F, 3'd0, 1'b0, 0, 0, 2};   // illegal
        tbl[13] = '{6'h01, 3'd3, 1'b1, 0, 0, 2};   // illegal

        rst_n = 1'b0;
        bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check(sample(), base(0), "reset_hold");
        rst_n = 1'b1;
        push(6'h00, 3'd0, 1'b0, 1'b1, base(0));
        run_queue(lat);

        for (int i = 0; i < 14; i++) begin
            build(tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].fwait, tbl[i].mwait);
            run_queue(lat);
            checks++;
            if (lat != tbl[i].exp_lat) begin
                errors++;
                $display("FAIL latency_op%02h: got %0d cycles want %0d", tbl[i].op, lat, tbl[i].exp_lat);
            end
        end

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 99) < 10) rop = 6'($urandom);
            else rop = legal_ops[$urandom_range(0, 6)];
            build(rop, 3'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
            run_queue(lat);
        end

        // Store stalled in memory write, then asynchronous reset between clock edges
        build(6'h2B, 3'd0, 1'b0, 0, 5);
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].exp.st == 4'd9) begin
                while (q.size() > i + 1) void'(q.pop_back());
                break;
            end
        end
        run_queue(lat);
        bus.mem_ready = 1'b0;
        #1;
        e = base(9); e.mem_wr = 1'b1; e.iord = 1'b1;
        check(sample(), e, "sd_stalled");
        rst_n = 1'b0;
        #1;
        check(sample(), base(0), "async_abort");
        repeat (2) @(posedge clk);
        #1;
        check(sample(), base(0), "reset_hold2");
        rst_n = 1'b1;
        push(6'h00, 3'd0, 1'b0, 1'b1, base(0));
        build(6'h23, 3'd0, 1'b0, 1, 2);
        run_queue(lat);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
